// File: rtl/lock_guard.sv
// lock_guard: attempt-limiting supervisor between keypad scanner and lock FSM.
// Forwards key events while usable, counts consecutive failed checks and
// enforces a timed lockout with countdown and blinking alarm.
module lock_guard #(
  parameter int TICK_CYCLES = 100000000 - 1,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_SECS   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keyboard_num,
  input  logic       keyboard_en,
  input  logic       pass_pulse,
  input  logic       fail_pulse,
  output logic [3:0] key_num_out,
  output logic       key_en_out,
  output logic       locked,
  output logic       alarm,
  output logic [2:0] fail_cnt,
  output logic [5:0] remain,
  output logic       last_chance
);

  localparam int PW = (TICK_CYCLES > 0) ? $clog2(TICK_CYCLES + 1) : 1;
  localparam logic [PW-1:0] TICK_TC   = PW'(TICK_CYCLES);
  localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAIL);
  localparam logic [2:0]    FAIL_LAST = 3'(MAX_FAIL - 1);
  localparam logic [5:0]    LOCK_INIT = 6'(LOCK_SECS);

  typedef enum logic {
    NORMAL,
    LOCKED
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] presc, presc_nxt;
  logic [2:0]    fail_inc, fail_nxt;
  logic [5:0]    remain_nxt;
  logic          locked_nxt, alarm_nxt, last_nxt;
  logic          tick;

  // Saturating increment so the counter can never wrap past MAX_FAIL.
  assign fail_inc = (fail_cnt == FAIL_MAX) ? FAIL_MAX : fail_cnt + 3'd1;
  assign tick     = (state == LOCKED) && (presc == TICK_TC);

  // Next-state and next-value logic for the supervisor.
  always_comb begin
    next_state = state;
    presc_nxt  = '0;
    fail_nxt   = fail_cnt;
    remain_nxt = remain;
    locked_nxt = locked;
    alarm_nxt  = alarm;
    last_nxt   = last_chance;
    case (state)
      NORMAL: begin
        if (pass_pulse) begin
          fail_nxt = '0;
          last_nxt = 1'b0;
        end else if (fail_pulse) begin
          fail_nxt = fail_inc;
          // After an expired lockout a single failure relocks; fail_cnt is
          // already MAX_FAIL-1 then, so both conditions coincide in practice.
          if ((fail_inc == FAIL_MAX) || last_chance) begin
            next_state = LOCKED;
            locked_nxt = 1'b1;
            remain_nxt = LOCK_INIT;
            alarm_nxt  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (!tick) begin
          presc_nxt = presc + PW'(1);
        end else if (remain <= 6'd1) begin
          next_state = NORMAL;
          remain_nxt = '0;
          locked_nxt = 1'b0;
          alarm_nxt  = 1'b0;
          fail_nxt   = FAIL_LAST;
          last_nxt   = 1'b1;
        end else begin
          remain_nxt = remain - 6'd1;
          alarm_nxt  = ~alarm;
        end
      end
      default: next_state = NORMAL;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= NORMAL;
      presc       <= '0;
      fail_cnt    <= '0;
      remain      <= '0;
      locked      <= 1'b0;
      alarm       <= 1'b0;
      last_chance <= 1'b0;
    end else begin
      state       <= next_state;
      presc       <= presc_nxt;
      fail_cnt    <= fail_nxt;
      remain      <= remain_nxt;
      locked      <= locked_nxt;
      alarm       <= alarm_nxt;
      last_chance <= last_nxt;
    end
  end

  // Registered key forwarding, gated by the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_num_out <= '0;
      key_en_out  <= 1'b0;
    end else begin
      key_en_out <= keyboard_en & (next_state == NORMAL);
      if (keyboard_en) key_num_out <= keyboard_num;
    end
  end

endmodule

// File: tb/tb_lock_guard.sv
// Self-checking bench for lock_guard: directed vector table, hand-written
// lockout sequences, and randomized stimulus against an elapsed-time model.
module tb_lock_guard;

  localparam int TICK = 9;
  localparam int MAXF = 3;
  localparam int SECS = 3;
  localparam int PER  = TICK + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyboard_num;
  logic       keyboard_en, pass_pulse, fail_pulse;
  logic [3:0] key_num_out;
  logic       key_en_out, locked, alarm, last_chance;
  logic [2:0] fail_cnt;
  logic [5:0] remain;

  int checks = 0;
  int failures = 0;

  lock_guard #(
    .TICK_CYCLES(TICK),
    .MAX_FAIL   (MAXF),
    .LOCK_SECS  (SECS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keyboard_num(keyboard_num),
    .keyboard_en (keyboard_en),
    .pass_pulse  (pass_pulse),
    .fail_pulse  (fail_pulse),
    .key_num_out (key_num_out),
    .key_en_out  (key_en_out),
    .locked      (locked),
    .alarm       (alarm),
    .fail_cnt    (fail_cnt),
    .remain      (remain),
    .last_chance (last_chance)
  );

  always #5 clk = ~clk;

  // Reference model: lockout tracked as elapsed cycles since entry.
  bit m_locked, m_last, m_ken;
  int m_fail, m_elapsed, m_knum;

  function automatic void model_reset();
    m_locked = 0; m_last = 0; m_ken = 0;
    m_fail = 0; m_elapsed = 0; m_knum = 0;
  endfunction

  function automatic void model_step(input bit ke, input int kn, input bit pp, input bit fp);
    if (!m_locked) begin
      if (pp) begin
        m_fail = 0;
        m_last = 0;
      end else if (fp) begin
        if (m_fail < MAXF) m_fail++;
        if (m_fail == MAXF || m_last) begin
          m_locked = 1;
          m_elapsed = 0;
        end
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == SECS * PER) begin
        m_locked = 0;
        m_fail = MAXF - 1;
        m_last = 1;
      end
    end
    m_ken = ke && !m_locked;
    if (ke) m_knum = kn;
  endfunction

  function automatic int model_remain();
    return m_locked ? SECS - m_elapsed / PER : 0;
  endfunction

  function automatic int model_alarm();
    return m_locked ? (((m_elapsed / PER) % 2) == 0) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ken, input int knum, input int fl,
                         input int lk, input int rm, input int al, input int lc);
    chk({tag, ".key_en_out"},  key_en_out,  ken);
    chk({tag, ".key_num_out"}, key_num_out, knum);
    chk({tag, ".fail_cnt"},    fail_cnt,    fl);
    chk({tag, ".locked"},      locked,      lk);
    chk({tag, ".remain"},      remain,      rm);
    chk({tag, ".alarm"},       alarm,       al);
    chk({tag, ".last_chance"}, last_chance, lc);
  endtask

  // One clock cycle of stimulus; returns at posedge+1 with strobes cleared.
  task automatic step(input logic ke, input logic [3:0] kn, input logic pp, input logic fp);
    keyboard_en = ke; keyboard_num = kn; pass_pulse = pp; fail_pulse = fp;
    @(posedge clk); #1;
    keyboard_en = 0; pass_pulse = 0; fail_pulse = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // Idle until locked drops, bounded; returns cycles waited.
  task automatic wait_unlock(input string tag, output int n);
    n = 0;
    while (locked && n < 100) begin
      step(0, 4'h0, 0, 0);
      n++;
    end
    chk({tag, ".unlock_timeout"}, locked, 0);
  endtask

  typedef struct {
    logic       ke;
    logic [3:0] kn;
    logic       pp;
    logic       fp;
    int ken, knum, fl, lk, rm, al, lc;
  } vec_t;

  function automatic vec_t mk(input logic ke, input logic [3:0] kn, input logic pp, input logic fp,
                              input int ken, input int knum, input int fl, input int lk,
                              input int rm, input int al, input int lc);
    vec_t v;
    v.ke = ke; v.kn = kn; v.pp = pp; v.fp = fp;
    v.ken = ken; v.knum = knum; v.fl = fl; v.lk = lk; v.rm = rm; v.al = al; v.lc = lc;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    int n;
    rst = 0; keyboard_en = 0; keyboard_num = 0; pass_pulse = 0; fail_pulse = 0;

    //                 ke kn    pp fp  ken knum fl lk rm al lc
    vecs[0]  = mk(1, 4'h7, 0, 0,  1, 7, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 4'h0, 0, 0,  0, 7, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 4'h0, 0, 1,  0, 7, 1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 4'h0, 0, 1,  0, 7, 2, 0, 0, 0, 0);
    vecs[4]  = mk(0, 4'h0, 1, 1,  0, 7, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 4'h0, 0, 1,  0, 7, 1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 4'h0, 0, 1,  0, 7, 2, 0, 0, 0, 0);
    vecs[7]  = mk(1, 4'h3, 0, 1,  0, 3, 3, 1, 3, 1, 0);
    vecs[8]  = mk(1, 4'h5, 0, 0,  0, 5, 3, 1, 3, 1, 0);
    vecs[9]  = mk(0, 4'h0, 1, 0,  0, 5, 3, 1, 3, 1, 0);
    vecs[10] = mk(0, 4'h0, 0, 1,  0, 5, 3, 1, 3, 1, 0);

    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].ke, vecs[i].kn, vecs[i].pp, vecs[i].fp);
      chk_all($sformatf("vec%0d", i), vecs[i].ken, vecs[i].knum, vecs[i].fl,
              vecs[i].lk, vecs[i].rm, vecs[i].al, vecs[i].lc);
    end

    // Countdown: lockout entered at vec7, three cycles already elapsed.
    n = 3;
    while (locked && n < 100) begin
      step(0, 4'h0, 0, 0);
      n++;
      if (n == 10) begin chk("cd10.remain", remain, 2); chk("cd10.alarm", alarm, 0); end
      if (n == 20) begin chk("cd20.remain", remain, 1); chk("cd20.alarm", alarm, 1); end
      if (n == 29) chk("cd29.locked", locked, 1);
    end
    chk("lock_len", n, SECS * PER);
    chk_all("expiry", 0, 5, MAXF - 1, 0, 0, 0, 1);

    step(1, 4'h9, 0, 0);
    chk_all("reenable", 1, 9, 2, 0, 0, 0, 1);

    step(0, 4'h0, 0, 1);
    chk_all("relock", 0, 9, 3, 1, 3, 1, 1);
    repeat (10) step(0, 4'h0, 0, 0);
    chk("relock10.remain", remain, 2);

    // Asynchronous reset mid-lockout, away from any clock edge.
    rst = 0;
    #1;
    chk_all("midreset", 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 4'hA, 0, 0);
    chk_all("postreset", 1, 10, 0, 0, 0, 0, 0);

    // Recovery: expire, then pass clears, then a single fail does not lock.
    repeat (3) step(0, 4'h0, 0, 1);
    chk("rec.locked", locked, 1);
    wait_unlock("rec", n);
    chk("rec.len", n, SECS * PER);
    step(0, 4'h0, 1, 0);
    chk_all("rec.pass", 0, 10, 0, 0, 0, 0, 0);
    step(0, 4'h0, 0, 1);
    chk_all("rec.fail", 0, 10, 1, 0, 0, 0, 0);

    // Randomized stimulus against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit ke, pp, fp;
      logic [3:0] kn;
      ke = ($urandom_range(0, 2) == 0);
      pp = ($urandom_range(0, 9) == 0);
      fp = ($urandom_range(0, 99) < 20);
      kn = 4'($urandom);
      step(ke, kn, pp, fp);
      model_step(ke, int'(kn), pp, fp);
      chk_all($sformatf("rnd%0d", c), m_ken, m_knum, m_fail, m_locked,
              model_remain(), model_alarm(), m_last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
